bound_flasher_sequencer: RTL and testbench
==========================================

# bound_flasher_sequencer

Lamp-sequencing state machine for the bound flasher. It owns the 5-bit lamp `counter` and drives the 16 thermometer-coded `lamps`. It consumes `kickback_match` from `kickback_match_generator` and sits on the other end of that interface. `counter` feeds the generator, and `kickback_match` comes back to abort and replay the current ON phase.

## Interface
- `STEP_DIV`, default 1: clock cycles per lamp step, range ≥1. A value of 1 steps every cycle.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: synchronous reset, active-high. It has priority over every other input.
- `flick`  in  1: start request. It is sampled only in IDLE.
- `kickback_match`  in  1: from `kickback_match_generator`. It is expected high when flick=1 and counter ∈ {6, 11}. It is sampled only at kickback points (see Operation) and ignored everywhere else.
- `counter`  out  5: number of lit lamps, range 0..16, registered.
- `lamps`  out  16: lamps[i] = (i < counter), registered, or combinational from the registered counter.
- `busy`  out  1: high whenever state ≠ IDLE.

## Operation
- Prescaler:
  - A free-running count of 0..STEP_DIV-1 raises `step` when it wraps.
  - All state and counter updates happen only on step cycles.
  - It is cleared by rst.
- States: IDLE, UP1, DN1, UP2, DN2, UP3, DN3, KB2, KB3.
- Step rules. The boundary value is held for exactly one step, and the counter moves in the new direction on that same step.
  - IDLE: counter=0.
    - flick=1 → UP1, counter←1.
    - flick=0 → stay in IDLE.
  - UP1: count up.
    - At 6 → DN1, counter←5.
  - DN1: count down.
    - At 0 → UP2, counter←1.
  - UP2: count up.
    - At 6 with kickback_match → KB2, counter←5.
    - At 11 with kickback_match → KB2, counter←10.
    - At 11 without kickback_match → DN2, counter←10.
  - KB2: count down.
    - At 0 → UP2, counter←1. This replays UP2.
  - DN2: count down.
    - At 6 → UP3, counter←7.
  - UP3: count up.
    - At 11 with kickback_match → KB3, counter←10.
    - At 16 → DN3, counter←15.
  - KB3: count down.
    - At 6 → UP3, counter←7.
  - DN3: count down.
    - At 0 → IDLE, counter stays 0.
- Kickback points:
  - UP2 at counter 6 and counter 11.
  - UP3 at counter 11 only. Counter 6 is the start of UP3 and is not a kickback point.
  - kickback_match is ignored in every other state and at every other value.
- flick deasserting mid-sequence has no effect. A started sequence always runs to IDLE unless rst is asserted.
- Repeated kickbacks are unbounded. Holding kickback_match high keeps the machine cycling UP2↔KB2.
- Width rules:
  - The counter never leaves 0..16.
  - counter=16 lights all lamps.
  - No wrap-around is possible. Any illegal state recovers to IDLE with counter=0 on the next step.

## Timing
- Reset values: state=IDLE, counter=0, lamps=16'h0000, busy=0, prescaler=0.
- rst asserted mid-sequence forces all reset values at the next edge, regardless of `step`.
- Latency from flick=1 sampled on a step edge in IDLE: counter=1, lamps=16'h0001 and busy=1 after that same edge.
- With STEP_DIV=1 and no kickbacks, counter by edge (E0 = the flick-sampling edge):
  - E0..E5: 1..6
  - E6..E11: 5..0
  - E12..E22: 1..11
  - E23..E27: 10..6
  - E28..E37: 7..16
  - E38..E53: 15..0
  - E54: IDLE, busy=0.
- Full run is 55 step edges. flick sampled at E55 restarts the sequence.
- With STEP_DIV=N, every value is held N cycles. Between steps, outputs are stable.

## Test plan
- Reset check:
  - Stimulus: rst=1 for 2 cycles, flick=0.
  - Required: counter=0, lamps=0, busy=0.
  - Stimulus: flick=0 held for 20 cycles.
  - Required: stays IDLE.
- Nominal run:
  - Stimulus: STEP_DIV=1, flick pulsed 1 cycle, kickback_match=0.
  - Required: the exact counter sequence above. lamps=16'h003F at E5, 16'h07FF at E22, 16'hFFFF at E37. busy=0 after E54.
- UP2 kickback at 6:
  - Stimulus: kickback_match=1 only while counter=6 in UP2, first time only.
  - Required: counter 6→5…0, then 1..11, then DN2. busy drops 12 edges later than nominal.
- UP3 kickback at 11:
  - Stimulus: kickback_match=1 only when counter=11 in UP3, once.
  - Required: counter 11→10…6→7…16→DN3. kickback_match at counter 6 in DN2/UP3 start is ignored.
- Mid-sequence reset:
  - Stimulus: rst at E30, when counter=9 in UP3.
  - Required: counter=0, lamps=0, busy=0 on the next edge.
  - Stimulus: flick afterwards.
  - Required: a fresh UP1.
- Prescaler:
  - Stimulus: STEP_DIV=4.
  - Required: each counter value is held exactly 4 cycles, and the full run takes 220 cycles.
  - Stimulus: flick dropped at E3.
  - Required: no change to the sequence.

Source files
------------

// File: rtl/bound_flasher_sequencer.sv
// Bound flasher lamp sequencer: drives a 0..16 lamp count up and down through three
// phases, with kickback replays of the UP2/UP3 phases requested by kickback_match.
module bound_flasher_sequencer #(
  parameter int unsigned STEP_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flick,
  input  logic        kickback_match,
  output logic [4:0]  counter,
  output logic [15:0] lamps,
  output logic        busy
);

  localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);

  typedef enum logic [3:0] {IDLE, UP1, DN1, UP2, DN2, UP3, DN3, KB2, KB3} state_e;

  state_e        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [15:0]   lamps_q, lamps_d;
  logic          busy_q;
  logic [PW-1:0] pre_q, pre_d;
  logic          step;

  assign step  = (pre_q == PRE_LAST);
  assign pre_d = step ? '0 : pre_q + 1'b1;

  // Up phases use >= and down phases use <= so a corrupted count still turns around in range.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (step) begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (flick) begin
            state_d = UP1;
            cnt_d   = 5'd1;
          end
        end
        UP1: begin
          if (cnt_q >= 5'd6) begin state_d = DN1; cnt_d = 5'd5; end
          else cnt_d = cnt_q + 5'd1;
        end
        DN1, KB2: begin
          if (cnt_q == 5'd0) begin state_d = UP2; cnt_d = 5'd1; end
          else cnt_d = cnt_q - 5'd1;
        end
        UP2: begin
          if (kickback_match && (cnt_q == 5'd6 || cnt_q == 5'd11)) begin
            state_d = KB2;
            cnt_d   = cnt_q - 5'd1;
          end else if (cnt_q >= 5'd11) begin
            state_d = DN2;
            cnt_d   = 5'd10;
          end else cnt_d = cnt_q + 5'd1;
        end
        DN2, KB3: begin
          if (cnt_q <= 5'd6) begin state_d = UP3; cnt_d = 5'd7; end
          else cnt_d = cnt_q - 5'd1;
        end
        UP3: begin
          if (kickback_match && cnt_q == 5'd11) begin
            state_d = KB3;
            cnt_d   = 5'd10;
          end else if (cnt_q >= 5'd16) begin
            state_d = DN3;
            cnt_d   = 5'd15;
          end else cnt_d = cnt_q + 5'd1;
        end
        DN3: begin
          if (cnt_q == 5'd0) begin state_d = IDLE; cnt_d = '0; end
          else cnt_d = cnt_q - 5'd1;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    lamps_d = '0;
    for (int unsigned i = 0; i < 16; i++) lamps_d[i] = (5'(i) < cnt_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lamps_q <= '0;
      busy_q  <= 1'b0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lamps_q <= lamps_d;
      busy_q  <= (state_d != IDLE);
      pre_q   <= pre_d;
    end
  end

  assign counter = cnt_q;
  assign lamps   = lamps_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_bound_flasher_sequencer.sv
// Directed bench for bound_flasher_sequencer: table-driven STEP_DIV=1 runs plus a
// hand-written STEP_DIV=4 prescaler sequence.
module tb_bound_flasher_sequencer;

  typedef struct {
    logic  rst;
    logic  flick;
    logic  kb;
    int    exp_cnt;
    logic  exp_busy;
    string name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst1, flick1, kb1, rst4, flick4, kb4;
  logic [4:0]  cnt1, cnt4;
  logic [15:0] lamps1, lamps4;
  logic        busy1, busy4;

  int   checks = 0;
  int   passes = 0;
  vec_t vecs[$];
  int   nom[$];

  always #5 clk = ~clk;

  bound_flasher_sequencer #(.STEP_DIV(1)) dut1 (
    .clk(clk), .rst(rst1), .flick(flick1), .kickback_match(kb1),
    .counter(cnt1), .lamps(lamps1), .busy(busy1)
  );

  bound_flasher_sequencer #(.STEP_DIV(4)) dut4 (
    .clk(clk), .rst(rst4), .flick(flick4), .kickback_match(kb4),
    .counter(cnt4), .lamps(lamps4), .busy(busy4)
  );

  function automatic logic [15:0] thermo(int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i] = (i < n);
    return r;
  endfunction

  task automatic chk(string name, int idx, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s[%0d]: got 'h%0h, expected 'h%0h", name, idx, act, exp);
  endtask

  task automatic add(logic r, logic f, logic k, int c, logic b, string n);
    vec_t v;
    v.rst = r; v.flick = f; v.kb = k; v.exp_cnt = c; v.exp_busy = b; v.name = n;
    vecs.push_back(v);
  endtask

  // Busy run from a to b inclusive; kb asserted only on the first edge of the ramp.
  task automatic ramp(int a, int b, logic k_first, string n);
    int stp;
    stp = (b >= a) ? 1 : -1;
    for (int v = a; ; v += stp) begin
      add(1'b0, 1'b0, (v == a) ? k_first : 1'b0, v, 1'b1, n);
      if (v == b) break;
    end
  endtask

  task automatic nramp(int a, int b);
    int stp;
    stp = (b >= a) ? 1 : -1;
    for (int v = a; ; v += stp) begin
      nom.push_back(v);
      if (v == b) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cycles;
    rst1 = 1'b1; flick1 = 1'b0; kb1 = 1'b0;
    rst4 = 1'b1; flick4 = 1'b0; kb4 = 1'b0;

    // reset and idle
    add(1, 0, 0, 0, 0, "rst");
    add(1, 0, 0, 0, 0, "rst");
    add(1, 1, 1, 0, 0, "rst_prio");
    for (int i = 0; i < 20; i++) add(0, 0, (i % 2) == 1, 0, 0, "idle");

    // nominal run E0..E54, then restart at E55
    add(0, 1, 0, 1, 1, "n_start");
    ramp(2, 6, 0, "n_up1");   ramp(5, 0, 0, "n_dn1");
    ramp(1, 11, 0, "n_up2");  ramp(10, 6, 0, "n_dn2");
    ramp(7, 16, 0, "n_up3");  ramp(15, 0, 0, "n_dn3");
    add(0, 0, 0, 0, 0, "n_idle");
    add(0, 1, 0, 1, 1, "n_restart");
    add(1, 0, 0, 0, 0, "rst");

    // UP2 kickback at 6, first pass only
    add(0, 1, 0, 1, 1, "k2_start");
    ramp(2, 6, 0, "k2_up1");  ramp(5, 0, 0, "k2_dn1");
    ramp(1, 6, 0, "k2_up2");  ramp(5, 0, 1, "k2_kb");
    ramp(1, 11, 0, "k2_up2b"); ramp(10, 6, 0, "k2_dn2");
    ramp(7, 16, 0, "k2_up3"); ramp(15, 0, 0, "k2_dn3");
    add(0, 0, 0, 0, 0, "k2_idle");
    add(0, 0, 0, 0, 0, "k2_idle");

    // UP3 kickback at 11; kb at UP1 top and at DN2 bottom is ignored
    add(0, 1, 0, 1, 1, "k3_start");
    ramp(2, 6, 0, "k3_up1");  ramp(5, 0, 1, "k3_ign_up1");
    ramp(1, 11, 0, "k3_up2"); ramp(10, 6, 0, "k3_dn2");
    ramp(7, 11, 1, "k3_ign_dn2"); ramp(10, 6, 1, "k3_kb");
    ramp(7, 16, 0, "k3_up3b"); ramp(15, 0, 0, "k3_dn3");
    add(0, 0, 0, 0, 0, "k3_idle");

    // UP2 kickback at 11
    add(0, 1, 0, 1, 1, "k11_start");
    ramp(2, 6, 0, "k11_up1"); ramp(5, 0, 0, "k11_dn1");
    ramp(1, 11, 0, "k11_up2"); ramp(10, 0, 1, "k11_kb");
    ramp(1, 3, 0, "k11_up2b");
    add(1, 0, 0, 0, 0, "rst");

    // reset at E30 (counter 9 in UP3), then a fresh UP1
    add(0, 1, 0, 1, 1, "mr_start");
    ramp(2, 6, 0, "mr_up1");  ramp(5, 0, 0, "mr_dn1");
    ramp(1, 11, 0, "mr_up2"); ramp(10, 6, 0, "mr_dn2");
    ramp(7, 9, 0, "mr_up3");
    add(1, 0, 0, 0, 0, "mr_rst");
    add(0, 0, 0, 0, 0, "mr_idle");
    add(0, 0, 0, 0, 0, "mr_idle");
    add(0, 1, 0, 1, 1, "mr_fresh");
    ramp(2, 6, 0, "mr_up1b"); ramp(5, 3, 0, "mr_dn1b");
    add(1, 0, 0, 0, 0, "rst");

    foreach (vecs[i]) begin
      rst1 = vecs[i].rst; flick1 = vecs[i].flick; kb1 = vecs[i].kb;
      @(posedge clk); #1;
      chk({vecs[i].name, "/cnt"}, i, {11'b0, cnt1}, 16'(vecs[i].exp_cnt));
      chk({vecs[i].name, "/lamps"}, i, lamps1, thermo(vecs[i].exp_cnt));
      chk({vecs[i].name, "/busy"}, i, {15'b0, busy1}, {15'b0, vecs[i].exp_busy});
    end

    // STEP_DIV=4: every nominal value held 4 cycles; flick held until E3
    nramp(1, 6); nramp(5, 0); nramp(1, 11); nramp(10, 6); nramp(7, 16); nramp(15, 0);
    nom.push_back(0);
    @(posedge clk); #1;
    chk("p_rst/cnt", 0, {11'b0, cnt4}, 16'd0);
    chk("p_rst/busy", 0, {15'b0, busy4}, 16'd0);
    rst4 = 1'b0; flick4 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("p_wait/cnt", c, {11'b0, cnt4}, 16'd0);
    end
    busy_cycles = 0;
    for (int k = 0; k < 55; k++) begin
      for (int j = 0; j < 4; j++) begin
        @(posedge clk); #1;
        if (k == 3 && j == 0) flick4 = 1'b0;
        if (busy4) busy_cycles++;
        chk("p_run/cnt", 4 * k + j, {11'b0, cnt4}, 16'(nom[k]));
        chk("p_run/lamps", 4 * k + j, lamps4, thermo(nom[k]));
        chk("p_run/busy", 4 * k + j, {15'b0, busy4}, {15'b0, k < 54});
      end
    end
    chk("p_busy_cycles", 0, 16'(busy_cycles), 16'd216);
    @(posedge clk); #1;
    chk("p_after/busy", 0, {15'b0, busy4}, 16'd0);
    chk("p_after/cnt", 0, {11'b0, cnt4}, 16'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
